// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: word-level SQI SRAM controller (command, address, dummy, data).
// Optional burst continuation is enabled by defining IDLI_SQI_BURST_EN.
module idli_sqi_mem_m #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int DUMMY_NIB = 2,
    parameter int HOLD_MAX  = 8
) (
    input  logic              i_sqm_gck,
    input  logic              i_sqm_rst,
    input  logic              i_sqm_req_vld,
    output logic              o_sqm_req_rdy,
    input  logic              i_sqm_req_wr,
    input  logic [ADDR_W-1:0] i_sqm_req_addr,
    input  logic [DATA_W-1:0] i_sqm_req_wdata,
    output logic              o_sqm_rsp_vld,
    output logic [DATA_W-1:0] o_sqm_rsp_rdata,
    output logic              o_sqm_sqi_sck,
    output logic              o_sqm_sqi_cs,
    output logic              o_sqm_sqi_mode,
    input  logic [3:0]        i_sqm_sqi_data,
    output logic [3:0]        o_sqm_sqi_data
);

    // Pin direction encoding on o_sqm_sqi_mode
    localparam logic SQI_MODE_OUT = 1'b0;
    localparam logic SQI_MODE_IN  = 1'b1;

    localparam int AB = $clog2(ADDR_W);
    localparam int DB = $clog2(DATA_W);

    localparam logic [7:0] L_ADDR_LAST = 8'(ADDR_W / 4 - 1);
    localparam logic [7:0] L_DATA_LAST = 8'(DATA_W / 4 - 1);
    localparam logic [7:0] L_DUM_LAST  = 8'((DUMMY_NIB > 0) ? DUMMY_NIB - 1 : 0);
    localparam logic [7:0] L_HOLD_LAST = 8'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [ADDR_W:0] L_STEP = (ADDR_W + 1)'(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_HOLD,
        S_END
    } state_t;

    state_t r_state;
    logic   r_phase;
    logic [7:0] r_cnt;
    logic [7:0] r_hold;

    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-5:0] r_rx;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rsp_vld;

    state_t w_state_nxt;
    logic   w_phase_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_hold_nxt;
    logic   w_accept;
    logic   w_done;
    logic   w_rdy;
    logic   w_match;
    logic   w_active;
    logic   w_rx_smp;

    logic [ADDR_W:0]   w_next_addr;
    logic [DATA_W-1:0] w_rx_ext;
    logic [7:0]        w_cmd;
    logic [AB-1:0]     w_a_bit;
    logic [DB-1:0]     w_d_bit;
    logic [3:0]        w_nib;

    assign w_next_addr = {1'b0, r_addr} + L_STEP;
    assign w_match = !w_next_addr[ADDR_W]
                   && (i_sqm_req_wr == r_wr)
                   && (i_sqm_req_addr == w_next_addr[ADDR_W-1:0]);

    assign w_cmd   = r_wr ? 8'h02 : 8'h03;
    assign w_a_bit = AB'({L_ADDR_LAST - r_cnt, 2'b00});
    assign w_d_bit = DB'({L_DATA_LAST - r_cnt, 2'b00});

    assign w_active = (r_state == S_CMD) || (r_state == S_ADDR)
                   || (r_state == S_DUMMY) || (r_state == S_DATA);

    // A read data nibble is captured at the edge that closes phase 1
    assign w_rx_smp = (r_state == S_DATA) && r_phase && !r_wr;
    assign w_rx_ext = {r_rx, i_sqm_sqi_data};

    // Next-state, slot counting and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_rdy       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_rdy = 1'b1;
                if (i_sqm_req_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CMD;
                    w_phase_nxt = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_CMD: begin
                w_phase_nxt = !r_phase;
                if (r_phase) begin
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_ADDR;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_ADDR: begin
                w_phase_nxt = !r_phase;
                if (r_phase) begin
                    if (r_cnt == L_ADDR_LAST) begin
                        w_cnt_nxt = 8'd0;
                        if (!r_wr && (DUMMY_NIB != 0))
                            w_state_nxt = S_DUMMY;
                        else
                            w_state_nxt = S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_DUMMY: begin
                w_phase_nxt = !r_phase;
                if (r_phase) begin
                    if (r_cnt == L_DUM_LAST) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_DATA: begin
                w_phase_nxt = !r_phase;
                if (r_phase) begin
                    if (r_cnt == L_DATA_LAST) begin
                        w_done     = 1'b1;
                        w_cnt_nxt  = 8'd0;
                        w_hold_nxt = 8'd0;
`ifdef IDLI_SQI_BURST_EN
                        w_state_nxt = w_next_addr[ADDR_W] ? S_END : S_HOLD;
`else
                        w_state_nxt = S_END;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_HOLD: begin
                w_rdy = w_match;
                if (i_sqm_req_vld) begin
                    if (w_match) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_DATA;
                        w_phase_nxt = 1'b0;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = S_END;
                    end
                end else if (r_hold == L_HOLD_LAST) begin
                    w_state_nxt = S_END;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            S_END: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_END;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge i_sqm_gck) begin
        if (i_sqm_rst) begin
            r_state <= S_END;
            r_phase <= 1'b0;
            r_cnt   <= 8'd0;
            r_hold  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Request latch, read shift register and response register
    always_ff @(posedge i_sqm_gck) begin
        if (i_sqm_rst) begin
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rx      <= '0;
            r_rdata   <= '0;
            r_rsp_vld <= 1'b0;
        end else begin
            r_rsp_vld <= w_done;
            if (w_accept) begin
                r_wr    <= i_sqm_req_wr;
                r_addr  <= i_sqm_req_addr;
                r_wdata <= i_sqm_req_wdata;
            end
            if (w_rx_smp)
                r_rx <= w_rx_ext[DATA_W-5:0];
            if (w_done)
                r_rdata <= r_wr ? '0 : w_rx_ext;
        end
    end

    // Outgoing nibble selection per phase of the transaction
    always_comb begin
        w_nib = 4'h0;
        if (r_state == S_CMD)
            w_nib = (r_cnt == 8'd0) ? w_cmd[7:4] : w_cmd[3:0];
        else if (r_state == S_ADDR)
            w_nib = r_addr[w_a_bit +: 4];
        else if ((r_state == S_DATA) && r_wr)
            w_nib = r_wdata[w_d_bit +: 4];
    end

    // Pin-level outputs derived from registered state
    always_comb begin
        o_sqm_sqi_sck  = w_active && r_phase;
        o_sqm_sqi_cs   = !(w_active || (r_state == S_HOLD));
        o_sqm_sqi_mode = SQI_MODE_OUT;
        if (r_state == S_DUMMY)
            o_sqm_sqi_mode = SQI_MODE_IN;
        else if (((r_state == S_DATA) || (r_state == S_HOLD)) && !r_wr)
            o_sqm_sqi_mode = SQI_MODE_IN;
        o_sqm_sqi_data = w_nib;
    end

    assign o_sqm_req_rdy   = w_rdy;
    assign o_sqm_rsp_vld   = r_rsp_vld;
    assign o_sqm_rsp_rdata = r_rdata;

endmodule
